// File: rtl/playfield_lock_clear_pkg.sv
// Shared board geometry, types and helpers for the playfield lock/clear writer.
// Row 0 is the top of the board; bit c of a row word is column c.
package playfield_lock_clear_pkg;

   localparam int          ROWS       = 22;
   localparam int          COLS       = 12;
   localparam int          SPAWN_ROWS = 2;
   localparam logic [11:0] WALL_MASK  = 12'h801;
   localparam logic [11:0] FULL_ROW   = 12'hFFF;

   typedef logic [3:0]  shape_t [4];
   typedef logic [11:0] board_t [ROWS];

   typedef enum logic [2:0] {
      IDLE,
      MERGE,
      SCAN,
      COLLAPSE,
      DONE
   } lock_state_e;

   // Score accumulator clamps at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {14'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/playfield_lock_clear_if.sv
// Lock request / board image bundle between the piece logic (master) and the
// playfield writer (slave).
interface playfield_lock_clear_if;
   import playfield_lock_clear_pkg::*;

   logic        clear_board;
   logic        lock_req;
   shape_t      shape;
   logic [4:0]  row_in;
   logic [3:0]  col_in;
   board_t      row_contents;
   logic        busy;
   logic        newgen;
   logic [2:0]  lines_cleared;
   logic [15:0] score;
   logic        game_over;

   modport master (
      output clear_board, lock_req, shape, row_in, col_in,
      input  row_contents, busy, newgen, lines_cleared, score, game_over
   );

   modport slave (
      input  clear_board, lock_req, shape, row_in, col_in,
      output row_contents, busy, newgen, lines_cleared, score, game_over
   );

endinterface

// File: rtl/playfield_lock_clear_merge.sv
// Combinational piece_merge: ORs a 4x4 piece into the board at (row, col) and
// flags a collision when a merged cell is already occupied or in the spawn zone.
module piece_merge
   import playfield_lock_clear_pkg::*;
(
   input  board_t     i_board,
   input  shape_t     i_shape,
   input  logic [4:0] i_row,
   input  logic [3:0] i_col,
   output board_t     o_board,
   output logic       o_collide
);

   logic [5:0] w_r;
   logic [4:0] w_c;

   always_comb begin
      o_board   = i_board;
      o_collide = 1'b0;
      w_r       = '0;
      w_c       = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            // Widened sums so off-board cells are dropped instead of wrapping.
            w_r = {1'b0, i_row} + 6'(i);
            w_c = {1'b0, i_col} + 5'(j);
            if (i_shape[2'(i)][2'(j)] && (w_r < 6'(ROWS)) && (w_c < 5'(COLS))) begin
               if (i_board[w_r[4:0]][w_c[3:0]] || (w_r < 6'(SPAWN_ROWS)))
                  o_collide = 1'b1;
               o_board[w_r[4:0]][w_c[3:0]] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/playfield_lock_clear.sv
// Playfield writer: merges a landed piece, clears full rows bottom-up, then
// requests the next piece. Also keeps the score and a sticky game-over flag.
module playfield_lock_clear
   import playfield_lock_clear_pkg::*;
(
   input  logic                  vsync,
   input  logic                  reset_n,
   playfield_lock_clear_if.slave bus
);

   lock_state_e r_state;
   shape_t      r_shape;
   logic [4:0]  r_row;
   logic [3:0]  r_col;
   board_t      r_board;
   logic [4:0]  r_ptr;
   logic [2:0]  r_cnt;
   logic [2:0]  r_lines;
   logic [15:0] r_score;
   logic        r_go;
   logic        r_newgen;

   board_t      w_merged;
   board_t      w_collapsed;
   logic        w_collide;
   logic        w_row_full;
   logic [4:0]  w_k;

   piece_merge u_merge (
      .i_board   (r_board),
      .i_shape   (r_shape),
      .i_row     (r_row),
      .i_col     (r_col),
      .o_board   (w_merged),
      .o_collide (w_collide)
   );

   assign w_row_full = (r_board[r_ptr] == FULL_ROW);

   // Rows 1..r_ptr drop by one; rows below the pointer keep their contents.
   always_comb begin
      w_collapsed    = r_board;
      w_k            = '0;
      w_collapsed[0] = WALL_MASK;
      for (int k = 1; k < ROWS; k++) begin
         w_k = 5'(k);
         if (w_k <= r_ptr)
            w_collapsed[w_k] = r_board[w_k - 5'd1];
      end
   end

   always_ff @(posedge vsync or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_shape  <= '{default: '0};
         r_row    <= '0;
         r_col    <= '0;
         r_board  <= '{default: WALL_MASK};
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_lines  <= '0;
         r_score  <= '0;
         r_go     <= 1'b0;
         r_newgen <= 1'b0;
      end else if (bus.clear_board) begin
         // New game: abandon any sequence in flight without announcing a piece.
         r_state  <= IDLE;
         r_board  <= '{default: WALL_MASK};
         r_ptr    <= '0;
         r_cnt    <= '0;
         r_lines  <= '0;
         r_score  <= '0;
         r_go     <= 1'b0;
         r_newgen <= 1'b0;
      end else begin
         r_newgen <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.lock_req && !r_go) begin
                  r_shape <= bus.shape;
                  r_row   <= bus.row_in;
                  r_col   <= bus.col_in;
                  r_state <= MERGE;
               end
            end
            MERGE: begin
               r_board <= w_merged;
               if (w_collide)
                  r_go <= 1'b1;
               r_cnt   <= '0;
               r_ptr   <= 5'(ROWS - 1);
               r_state <= SCAN;
            end
            SCAN: begin
               if (w_row_full)
                  r_state <= COLLAPSE;
               else if (r_ptr == 5'd0)
                  r_state <= DONE;
               else
                  r_ptr <= r_ptr - 5'd1;
            end
            COLLAPSE: begin
               // Pointer stays put so the row that just slid down is rechecked.
               r_board <= w_collapsed;
               r_cnt   <= r_cnt + 3'd1;
               r_state <= SCAN;
            end
            DONE: begin
               r_newgen <= 1'b1;
               r_lines  <= r_cnt;
               r_score  <= sat_add16(r_score, r_cnt);
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.row_contents  = r_board;
   assign bus.busy          = (r_state != IDLE);
   assign bus.newgen        = r_newgen;
   assign bus.lines_cleared = r_lines;
   assign bus.score         = r_score;
   assign bus.game_over     = r_go;

endmodule

// File: tb/tb_playfield_lock_clear.sv
// Bench for playfield_lock_clear: a board-level reference model checked every
// cycle, plus directed lock scenarios with hand-computed board/latency values.
module tb_playfield_lock_clear;
   import playfield_lock_clear_pkg::*;

   logic vsync;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   bit   chk_on = 0;

   playfield_lock_clear_if pif ();

   playfield_lock_clear dut (
      .vsync   (vsync),
      .reset_n (reset_n),
      .bus     (pif)
   );

   initial begin
      vsync = 1'b0;
      forever #5 vsync = ~vsync;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [11:0] m_board [22];
   bit          m_busy, m_newgen, m_go, m_go_pend;
   int          m_cnt, m_len, m_lines_pend, m_lines, m_score;

   function automatic void m_reset();
      for (int r = 0; r < 22; r++) m_board[r] = 12'h801;
      m_busy = 0; m_newgen = 0; m_go = 0; m_go_pend = 0;
      m_cnt = 0; m_len = 0; m_lines_pend = 0; m_lines = 0; m_score = 0;
   endfunction

   // Drop the piece into the board, then remove full rows and let the rest fall.
   function automatic void m_lock(input logic [15:0] s, input int row, input int col);
      logic [11:0] keep [$];
      int r, c;
      m_go_pend = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            if (s[4*i+j]) begin
               r = row + i;
               c = col + j;
               if (r < 22 && c < 12) begin
                  if (m_board[r][c] || r < 2) m_go_pend = 1;
                  m_board[r][c] = 1'b1;
               end
            end
      for (int rr = 21; rr >= 0; rr--)
         if (m_board[rr] != 12'hFFF) keep.push_back(m_board[rr]);
      m_lines_pend = 22 - keep.size();
      for (int rr = 21; rr >= 0; rr--)
         m_board[rr] = ((21 - rr) < keep.size()) ? keep[21 - rr] : 12'h801;
      m_len = 24 + 2 * m_lines_pend;
   endfunction

   initial begin
      logic [15:0] sh;
      m_reset();
      forever begin
         @(posedge vsync or negedge reset_n);
         if (!reset_n || pif.clear_board) begin
            m_reset();
         end else begin
            m_newgen = 0;
            if (m_busy) begin
               m_cnt++;
               if (m_cnt == 1) m_go = m_go | m_go_pend;
               if (m_cnt == m_len) begin
                  m_busy   = 0;
                  m_newgen = 1;
                  m_lines  = m_lines_pend;
                  m_score  = (m_score + m_lines_pend > 65535) ? 65535 : m_score + m_lines_pend;
               end
            end else if (pif.lock_req && !m_go) begin
               for (int i = 0; i < 4; i++) sh[4*i +: 4] = pif.shape[i];
               m_lock(sh, int'(pif.row_in), int'(pif.col_in));
               m_busy = 1;
               m_cnt  = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      int rb;
      forever begin
         @(negedge vsync);
         if (chk_on) begin
            chk("busy",          32'(pif.busy),          32'(m_busy));
            chk("newgen",        32'(pif.newgen),        32'(m_newgen));
            chk("game_over",     32'(pif.game_over),     32'(m_go));
            chk("lines_cleared", 32'(pif.lines_cleared), 32'(m_lines));
            chk("score",         32'(pif.score),         32'(m_score));
            if (!m_busy) begin
               rb = 21;
               for (int r = 0; r < 22; r++)
                  if (pif.row_contents[r] !== m_board[r]) rb = r;
               chk($sformatf("board_row%0d", rb), 32'(pif.row_contents[rb]), 32'(m_board[rb]));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_shape(input logic [15:0] s);
      for (int i = 0; i < 4; i++) pif.shape[i] = s[4*i +: 4];
   endtask

   task automatic do_lock(input logic [15:0] s, input logic [4:0] row, input logic [3:0] col,
                          output int lat);
      @(negedge vsync);
      set_shape(s);
      pif.row_in   = row;
      pif.col_in   = col;
      pif.lock_req = 1'b1;
      @(negedge vsync);
      pif.lock_req = 1'b0;
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge vsync);
         #1;
         if (pif.newgen) begin
            lat = n;
            break;
         end
      end
      @(negedge vsync);
   endtask

   task automatic pulse_clear();
      @(negedge vsync);
      pif.clear_board = 1'b1;
      @(negedge vsync);
      pif.clear_board = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int lat, ng;
      reset_n         = 1'b0;
      pif.clear_board = 1'b0;
      pif.lock_req    = 1'b0;
      set_shape(16'h0000);
      pif.row_in      = '0;
      pif.col_in      = '0;
      repeat (3) @(negedge vsync);
      reset_n = 1'b1;
      chk_on  = 1;
      @(negedge vsync);
      chk("rst_row0",  32'(pif.row_contents[0]),  32'h801);
      chk("rst_row21", 32'(pif.row_contents[21]), 32'h801);
      chk("rst_busy",  32'(pif.busy), 32'd0);

      // Horizontal I on the floor, nothing clears.
      do_lock(16'h000F, 5'd21, 4'd1, lat);
      chk("t2_latency", 32'(lat), 32'd24);
      chk("t2_row21", 32'(pif.row_contents[21]), 32'h81F);
      chk("t2_model_row21", 32'(m_board[21]), 32'h81F);
      chk("t2_lines", 32'(pif.lines_cleared), 32'd0);

      // Build row 21 = F87 (row 20 = 803), then fill the gap with an I.
      pulse_clear();
      do_lock(16'h0031, 5'd20, 4'd1, lat);
      do_lock(16'h000F, 5'd21, 4'd7, lat);
      chk("t3_prefill_row21", 32'(pif.row_contents[21]), 32'hF87);
      chk("t3_prefill_row20", 32'(pif.row_contents[20]), 32'h803);
      do_lock(16'h000F, 5'd21, 4'd3, lat);
      chk("t3_latency", 32'(lat), 32'd26);
      chk("t3_row21", 32'(pif.row_contents[21]), 32'h803);
      chk("t3_row20", 32'(pif.row_contents[20]), 32'h801);
      chk("t3_row0",  32'(pif.row_contents[0]),  32'h801);
      chk("t3_lines", 32'(pif.lines_cleared), 32'd1);
      chk("t3_score", 32'(pif.score), 32'd1);
      chk("t3_model_score", 32'(m_score), 32'd1);

      // Reset asserted in the middle of a scan.
      @(negedge vsync);
      set_shape(16'h000F);
      pif.row_in = 5'd10; pif.col_in = 4'd1; pif.lock_req = 1'b1;
      @(negedge vsync);
      pif.lock_req = 1'b0;
      repeat (6) @(negedge vsync);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_busy",  32'(pif.busy),  32'd0);
      chk("t1_score", 32'(pif.score), 32'd0);
      chk("t1_go",    32'(pif.game_over), 32'd0);
      for (int r = 0; r < 22; r++)
         chk($sformatf("t1_row%0d", r), 32'(pif.row_contents[r]), 32'h801);
      @(negedge vsync);
      reset_n = 1'b1;

      // Tetris: rows 18..21 = FFD, then a vertical I in column 1.
      do_lock(16'hFFFF, 5'd18, 4'd2, lat);
      do_lock(16'hFFFF, 5'd18, 4'd7, lat);
      do_lock(16'h1111, 5'd18, 4'd6, lat);
      chk("t4_prefill_row18", 32'(pif.row_contents[18]), 32'hFFD);
      chk("t4_prefill_row21", 32'(pif.row_contents[21]), 32'hFFD);
      do_lock(16'h1111, 5'd18, 4'd1, lat);
      chk("t4_latency", 32'(lat), 32'd32);
      chk("t4_lines", 32'(pif.lines_cleared), 32'd4);
      chk("t4_score", 32'(pif.score), 32'd4);
      chk("t4_row18", 32'(pif.row_contents[18]), 32'h801);
      chk("t4_row21", 32'(pif.row_contents[21]), 32'h801);

      // Lock touching the spawn zone ends the game; later requests are ignored.
      do_lock(16'h000F, 5'd0, 4'd1, lat);
      chk("t5_latency", 32'(lat), 32'd24);
      chk("t5_go", 32'(pif.game_over), 32'd1);
      chk("t5_row0", 32'(pif.row_contents[0]), 32'h81F);
      pif.lock_req = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge vsync);
         chk("t5_busy_ignored", 32'(pif.busy), 32'd0);
      end
      pif.lock_req = 1'b0;
      pulse_clear();
      chk("t5_go_cleared", 32'(pif.game_over), 32'd0);
      chk("t5_row0_cleared", 32'(pif.row_contents[0]), 32'h801);

      // lock_req held across the busy period gives one sequence only.
      @(negedge vsync);
      set_shape(16'h000F);
      pif.row_in = 5'd21; pif.col_in = 4'd1; pif.lock_req = 1'b1;
      ng = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge vsync);
         if (n == 19) pif.lock_req = 1'b0;
         if (pif.newgen) ng++;
      end
      chk("t6_held_newgen_count", 32'(ng), 32'd1);
      chk("t6_held_row21", 32'(pif.row_contents[21]), 32'h81F);
      pulse_clear();

      // Columns past the right edge are dropped; column 11 overlaps the wall.
      do_lock(16'h000F, 5'd21, 4'd10, lat);
      chk("t6_edge_latency", 32'(lat), 32'd24);
      chk("t6_edge_row21", 32'(pif.row_contents[21]), 32'hC01);
      chk("t6_edge_go", 32'(pif.game_over), 32'd1);
      pulse_clear();

      // clear_board while the first full row is being collapsed.
      do_lock(16'hFFFF, 5'd18, 4'd1, lat);
      do_lock(16'hFFFF, 5'd18, 4'd5, lat);
      @(negedge vsync);
      set_shape(16'h3333);
      pif.row_in = 5'd18; pif.col_in = 4'd9; pif.lock_req = 1'b1;
      @(negedge vsync);
      pif.lock_req = 1'b0;
      repeat (2) @(negedge vsync);
      pif.clear_board = 1'b1;
      @(negedge vsync);
      pif.clear_board = 1'b0;
      chk("t6_abort_busy", 32'(pif.busy), 32'd0);
      ng = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge vsync);
         if (pif.newgen) ng++;
      end
      chk("t6_abort_newgen_count", 32'(ng), 32'd0);
      chk("t6_abort_row21", 32'(pif.row_contents[21]), 32'h801);
      chk("t6_abort_score", 32'(pif.score), 32'd0);

      @(negedge vsync);
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
